// File: rtl/fpu_rr_arbiter.sv
// Round-robin arbiter sharing one half-precision FPU core between N_REQ requesters.
// Optional WAIT watchdog is enabled by defining FPU_ARB_TIMEOUT_EN.
//
// state   | meaning
// S_IDLE  | no operation in flight, arbitrating over req
// S_ISSUE | grant and start pulses out, operands latched
// S_WAIT  | waiting for core ready/error (or watchdog)
// S_RESPOND | rsp_valid pulse to the winner
module fpu_rr_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [16*N_REQ-1:0]   req_a,
  input  logic [16*N_REQ-1:0]   req_b,
  input  logic [2*N_REQ-1:0]    req_op,
  output logic [N_REQ-1:0]      grant,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [15:0]           rsp_result,
  output logic                  rsp_error,
  output logic                  busy,
  output logic                  fpu_start,
  output logic [15:0]           fpu_a,
  output logic [15:0]           fpu_b,
  output logic [1:0]            fpu_op,
  input  logic                  fpu_ready,
  input  logic                  fpu_error,
  input  logic [15:0]           fpu_result
);

  localparam int PTR_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("fpu_rr_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [15:0]        rsp_result_q, rsp_result_d;
  logic               rsp_error_q, rsp_error_d;
  logic               busy_q, busy_d;
  logic               fpu_start_q, fpu_start_d;
  logic [15:0]        fpu_a_q, fpu_a_d;
  logic [15:0]        fpu_b_q, fpu_b_d;
  logic [1:0]         fpu_op_q, fpu_op_d;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   cand;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

  function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < N_REQ; i++) v[i] = (idx == PTR_W'(i));
    return v;
  endfunction

  // Search starts just after the last winner so every pending requester is reached.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = '0;
    rsp_valid_d  = '0;
    fpu_start_d  = 1'b0;
    rsp_result_d = rsp_result_q;
    rsp_error_d  = rsp_error_q;
    fpu_a_d      = fpu_a_q;
    fpu_b_d      = fpu_b_q;
    fpu_op_d     = fpu_op_q;
`ifdef FPU_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d     = S_ISSUE;
          ptr_d       = win_idx;
          grant_d     = onehot(win_idx);
          fpu_start_d = 1'b1;
          for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
              fpu_a_d  = req_a[16*i +: 16];
              fpu_b_d  = req_b[16*i +: 16];
              fpu_op_d = req_op[2*i +: 2];
            end
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef FPU_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (fpu_ready || fpu_error) begin
          state_d      = S_RESPOND;
          rsp_valid_d  = onehot(ptr_q);
          rsp_result_d = fpu_result;
          rsp_error_d  = fpu_error;
        end
`ifdef FPU_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d      = S_RESPOND;
          rsp_valid_d  = onehot(ptr_q);
          rsp_result_d = 16'h7C00;
          rsp_error_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= PTR_W'(N_REQ - 1);
      grant_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_error_q  <= 1'b0;
      busy_q       <= 1'b0;
      fpu_start_q  <= 1'b0;
      fpu_a_q      <= '0;
      fpu_b_q      <= '0;
      fpu_op_q     <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_error_q  <= rsp_error_d;
      busy_q       <= busy_d;
      fpu_start_q  <= fpu_start_d;
      fpu_a_q      <= fpu_a_d;
      fpu_b_q      <= fpu_b_d;
      fpu_op_q     <= fpu_op_d;
    end
  end

`ifdef FPU_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`endif

  assign grant      = grant_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_error  = rsp_error_q;
  assign busy       = busy_q;
  assign fpu_start  = fpu_start_q;
  assign fpu_a      = fpu_a_q;
  assign fpu_b      = fpu_b_q;
  assign fpu_op     = fpu_op_q;

endmodule
